// File: rtl/fpga_link_pkg.sv
// -----------------------------------------------------------------------------
// fpga_link_pkg
// Shared definitions for the FPGA-to-FPGA pulse-handshake serial link.
// - link_state_e   : handshake state encoding, common to transmitter and receiver
// - LINK_DATA_WIDTH: default frame width in bits
// - LINK_ACK_TIMEOUT: default acknowledge timeout in clock cycles
// - is_wait_state(): true for the states that listen for acknowledge
// -----------------------------------------------------------------------------
package fpga_link_pkg;

  localparam int LINK_DATA_WIDTH  = 8;
  localparam int LINK_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_PULSE = 3'd1,
    START_WAIT  = 3'd2,
    BIT_SETUP   = 3'd3,
    BIT_PULSE   = 3'd4,
    BIT_WAIT    = 3'd5,
    FIN_PULSE   = 3'd6,
    FIN_WAIT    = 3'd7
  } link_state_e;

  function automatic logic is_wait_state(input link_state_e s);
    return (s == START_WAIT) || (s == BIT_WAIT) || (s == FIN_WAIT);
  endfunction

endpackage

// File: rtl/fpga_transmitter_if.sv
// -----------------------------------------------------------------------------
// fpga_transmitter_if
// Bundles the transmitter's local request/status signals and the link-side
// handshake signals.
//   load, data_in      : local logic -> transmitter (start request, word)
//   busy, done, error  : transmitter -> local logic (status)
//   send, serial_out,
//   finish             : transmitter -> receiver (link strobes and data bit)
//   acknowledge        : receiver -> transmitter (one pulse per handshake)
// Modports: master = transmitter side, slave = the side driving load/ack.
// -----------------------------------------------------------------------------
interface fpga_transmitter_if
  import fpga_link_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH
) ();

  logic                  load;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  send;
  logic                  serial_out;
  logic                  finish;
  logic                  acknowledge;

  modport master (
    input  load, data_in, acknowledge,
    output busy, done, error, send, serial_out, finish
  );

  modport slave (
    output load, data_in, acknowledge,
    input  busy, done, error, send, serial_out, finish
  );

endinterface

// File: rtl/fpga_ack_sync.sv
// -----------------------------------------------------------------------------
// fpga_ack_sync
// Brings an acknowledge from another clock domain into this one: two-flop
// synchronizer followed by a rising-edge detector, so each incoming pulse (of
// any width) yields exactly one single-cycle pulse, two cycles later.
//   clock       : local clock
//   reset       : asynchronous, active-low
//   i_ack       : raw acknowledge from the receiver
//   o_ack_pulse : synchronized one-cycle acknowledge pulse
// -----------------------------------------------------------------------------
module fpga_ack_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_ack,
  output logic o_ack_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_ack;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_ack_pulse = r_sync & ~r_sync_d;

endmodule

// File: rtl/fpga_transmitter.sv
// -----------------------------------------------------------------------------
// fpga_transmitter
// Sending half of the FPGA-to-FPGA pulse-handshake serial link. A word loaded
// from local logic is sent as: start pulse on send, one send strobe per data
// bit (MSB first) with the bit on serial_out, then a finish pulse. Every pulse
// waits for an acknowledge from the receiver; if none arrives within
// ACK_TIMEOUT cycles the frame is aborted with a one-cycle error pulse.
//
// Parameters:
//   DATA_WIDTH  : bits per frame (>= 1)
//   ACK_TIMEOUT : cycles to wait for acknowledge in any wait state (>= 1)
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low, clears all state
//   link  : fpga_transmitter_if.master (load/data_in/busy/done/error and the
//           send/serial_out/finish/acknowledge link handshake)
// Configuration macro:
//   FPGA_TX_ACK_SYNC_EN : when defined, acknowledge goes through
//                         fpga_ack_sync (2-flop sync + edge detect, +2 cycles
//                         of latency, counted against the timeout).
// -----------------------------------------------------------------------------
module fpga_transmitter
  import fpga_link_pkg::*;
#(
  parameter int DATA_WIDTH  = LINK_DATA_WIDTH,
  parameter int ACK_TIMEOUT = LINK_ACK_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  fpga_transmitter_if.master  link
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // The counter holds the number of wait cycles already completed, so the
  // last permitted wait cycle is the one where it equals ACK_TIMEOUT-1.
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  link_state_e           r_state;
  link_state_e           w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [BW-1:0]         r_bit_cnt;
  logic [BW-1:0]         w_bit_next;
  logic [TW-1:0]         r_to_cnt;
  logic [TW-1:0]         w_to_next;
  logic                  r_done;
  logic                  r_error;
  logic                  w_done_next;
  logic                  w_error_next;
  logic                  w_timeout;
  logic                  w_ack;

`ifdef FPGA_TX_ACK_SYNC_EN
  fpga_ack_sync u_ack_sync (
    .clock       (clock),
    .reset       (reset),
    .i_ack       (link.acknowledge),
    .o_ack_pulse (w_ack)
  );
`else
  assign w_ack = link.acknowledge;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_next;
      r_to_cnt  <= w_to_next;
      r_done    <= w_done_next;
      r_error   <= w_error_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_cnt;
    w_to_next    = r_to_cnt;
    w_done_next  = 1'b0;
    w_error_next = 1'b0;
    w_timeout    = (r_to_cnt == TO_LAST);

    case (r_state)
      IDLE: begin
        if (link.load) begin
          w_shift_next = link.data_in;
          w_bit_next   = BIT_LAST;
          w_next       = START_PULSE;
        end
      end
      START_PULSE: begin
        w_to_next = '0;
        w_next    = START_WAIT;
      end
      START_WAIT: begin
        if (w_ack) w_next = BIT_SETUP;
      end
      BIT_SETUP: begin
        w_next = BIT_PULSE;
      end
      BIT_PULSE: begin
        w_to_next = '0;
        w_next    = BIT_WAIT;
      end
      BIT_WAIT: begin
        if (w_ack) begin
          w_shift_next = r_shift << 1;
          if (r_bit_cnt == '0) begin
            w_next = FIN_PULSE;
          end else begin
            w_bit_next = r_bit_cnt - 1'b1;
            w_next     = BIT_SETUP;
          end
        end
      end
      FIN_PULSE: begin
        w_to_next = '0;
        w_next    = FIN_WAIT;
      end
      FIN_WAIT: begin
        if (w_ack) begin
          w_done_next = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase

    // Shared timeout handling for all wait states; an acknowledge in the
    // same cycle as the timeout takes priority.
    if (is_wait_state(r_state) && !w_ack) begin
      if (w_timeout) begin
        w_error_next = 1'b1;
        w_next       = IDLE;
      end else begin
        w_to_next = r_to_cnt + 1'b1;
      end
    end
  end

  // Moore decode: outputs depend only on registered state.
  assign link.busy       = (r_state != IDLE);
  assign link.send       = (r_state == START_PULSE) || (r_state == BIT_PULSE);
  assign link.finish     = (r_state == FIN_PULSE);
  assign link.serial_out = ((r_state == BIT_SETUP) || (r_state == BIT_PULSE) ||
                            (r_state == BIT_WAIT)) & r_shift[DATA_WIDTH-1];
  assign link.done       = r_done;
  assign link.error      = r_error;

endmodule

// File: tb/tb_fpga_transmitter.sv
`timescale 1ns/1ps
module tb_fpga_transmitter;

  localparam int W   = 8;
  localparam int T   = 4;
  localparam int NHS = W + 2;   // handshakes per frame: start, W bits, finish
`ifdef FPGA_TX_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
`else
  localparam int ACK_LAT = 0;
`endif
  localparam bit STRAY_OK   = (ACK_LAT == 0);
  localparam int NUM_RANDOM = 30;

  typedef struct packed {
    int          load_cyc;
    int          lat;
    logic        is_err;
    int          nbits;
    logic [31:0] bits;
    int          nfin;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];
  int   pulses[$];
  int   pd[NHS];
  bit   pstray[NHS];

  fpga_transmitter_if #(.DATA_WIDTH(W)) link ();

  fpga_transmitter #(.DATA_WIDTH(W), .ACK_TIMEOUT(T)) dut (
    .clock (clock),
    .reset (reset),
    .link  (link)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 50000", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference model: what a frame must look like, from the link rules.
  // Cycles from the start pulse to the done/error cycle: each acknowledged
  // pulse costs (ack delay + sync latency + 1), a timed-out pulse costs
  // T + 1, and each data bit adds one setup cycle before its pulse.
  function automatic exp_t model(input logic [W-1:0] data, input int to_idx, input int load_cyc);
    exp_t e;
    int   last;
    e.load_cyc = load_cyc;
    e.is_err   = (to_idx >= 0);
    last       = e.is_err ? to_idx : NHS - 1;
    e.lat      = 0;
    for (int h = 0; h <= last; h++) begin
      if (h >= 1 && h <= W) e.lat += 1;
      if (e.is_err && h == to_idx) e.lat += T + 1;
      else                         e.lat += pd[h] + ACK_LAT + 1;
    end
    e.nbits = (e.is_err && to_idx < W) ? to_idx : W;
    e.bits  = 32'(data) >> (W - e.nbits);
    e.nfin  = (!e.is_err || to_idx == NHS - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic tick();
    @(negedge clock);
    if (link.send || link.finish) pulses.push_back(cyc);
  endtask

  task automatic plan_uniform(input int d);
    for (int h = 0; h < NHS; h++) begin
      pd[h]     = d;
      pstray[h] = 1'b0;
    end
  endtask

  task automatic plan_random();
    for (int h = 0; h < NHS; h++) begin
      pd[h]     = $urandom_range(T - ACK_LAT, 1);
      pstray[h] = STRAY_OK && (h != NHS - 1) && ($urandom_range(3, 0) == 0);
    end
  endtask

  // Called at a negedge with the DUT idle (or in its done/error cycle).
  // Returns at the negedge of the frame's done/error cycle.
  task automatic run_frame(input logic [W-1:0] data, input int to_idx,
                           input bit hold, input bit do_reset);
    int P;
    int g;
    pulses.delete();
    link.data_in = data;
    link.load    = 1'b1;
    if (!do_reset) exp_q.push_back(model(data, to_idx, cyc));
    tick();
    link.load    = hold;
    link.data_in = W'($urandom);
    for (int h = 0; h < NHS; h++) begin
      g = 0;
      while (pulses.size() <= h && g < 4 * T + 8) begin
        tick();
        g++;
      end
      if (pulses.size() <= h) begin
        check("pulse_seen", pulses.size(), h + 1);
        break;
      end
      P = pulses[h];
      if (do_reset && h == 4) begin
        tick();
        #2 reset = 1'b0;
        #1;
        check("rst_busy",   link.busy,       0);
        check("rst_send",   link.send,       0);
        check("rst_finish", link.finish,     0);
        check("rst_serial", link.serial_out, 0);
        check("rst_done",   link.done,       0);
        check("rst_error",  link.error,      0);
        tick();
        tick();
        reset     = 1'b1;
        link.load = 1'b0;
        tick();
        check("post_rst_busy", link.busy, 0);
        return;
      end
      if (h == to_idx) break;
      while (cyc < P + pd[h]) tick();
      link.acknowledge = 1'b1;
      tick();
      if (pstray[h]) tick();
      link.acknowledge = 1'b0;
    end
    g = 0;
    while (link.busy && g < 4 * T + 12) begin
      tick();
      g++;
    end
    if (link.busy) check("frame_end_seen", link.busy, 0);
  endtask

  // Monitor / scoreboard: reconstructs each frame from the link pins and
  // compares it with the expected record when done or error appears.
  logic        prev_busy = 1'b0;
  int          start_cyc = 0;
  int          got_nb    = 0;
  int          got_fin   = 0;
  logic [31:0] got_bits  = '0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      check("send_finish_excl", link.send & link.finish, 0);
      if (link.busy && !prev_busy) begin
        start_cyc = cyc;
        got_nb    = 0;
        got_fin   = 0;
        got_bits  = '0;
        check("start_send", link.send, 1);
      end else if (link.busy) begin
        if (link.send) begin
          got_bits = (got_bits << 1) | 32'(link.serial_out);
          got_nb++;
        end
        if (link.finish) got_fin++;
      end
      if (link.done || link.error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("end_is_error",    link.error,              e.is_err);
          check("done_error_excl", link.done & link.error,  0);
          check("end_busy",        link.busy,               0);
          check("bit_count",       got_nb,                  e.nbits);
          check("bit_values",      got_bits,                e.bits);
          check("finish_count",    got_fin,                 e.nfin);
          check("start_cycle",     start_cyc,               e.load_cyc + 1);
          check("frame_latency",   cyc - start_cyc,         e.lat);
        end
      end
      prev_busy = link.busy;
    end
  end

  initial begin
    bit hold;
    int to_idx;
    link.load        = 1'b0;
    link.data_in     = '0;
    link.acknowledge = 1'b0;
    reset            = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_busy",   link.busy,       0);
    check("reset_done",   link.done,       0);
    check("reset_error",  link.error,      0);
    check("reset_send",   link.send,       0);
    check("reset_finish", link.finish,     0);
    check("reset_serial", link.serial_out, 0);
    reset = 1'b1;
    tick();

    // 0xA5 with fixed ack delay
    plan_uniform(ACK_LAT > 0 ? 1 : 2);
    run_frame(8'hA5, -1, 1'b0, 1'b0);
    repeat (2) tick();

    // no acknowledge to the start pulse: timeout, link stays quiet afterwards
    plan_uniform(1);
    run_frame(W'($urandom), 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("quiet_after_error", link.send | link.finish, 0);
    end

    // load held through a frame, stray ack in BIT_SETUP, back-to-back frame
    plan_uniform(1);
    pstray[0] = STRAY_OK;
    run_frame(W'($urandom), -1, 1'b1, 1'b0);
    plan_uniform(2 - (ACK_LAT > 0 ? 1 : 0));
    run_frame(W'($urandom), -1, 1'b0, 1'b0);
    repeat (2) tick();

    // reset during the 4th bit's wait
    plan_uniform(1);
    run_frame(W'($urandom) | W'(8'h10), -1, 1'b0, 1'b1);
    repeat (3) tick();

    // acknowledge lands in the same cycle as the timeout
    plan_uniform(T - ACK_LAT);
    run_frame(W'($urandom), -1, 1'b0, 1'b0);
    tick();

    // timeout on the finish handshake
    plan_uniform(1);
    run_frame(W'($urandom), NHS - 1, 1'b0, 1'b0);
    tick();

    hold = 1'b0;
    for (int i = 0; i < NUM_RANDOM; i++) begin
      if (!hold) repeat ($urandom_range(2, 0)) tick();
      plan_random();
      to_idx = ($urandom_range(4, 0) == 0) ? $urandom_range(NHS - 1, 0) : -1;
      hold   = (i != NUM_RANDOM - 1) && ($urandom_range(2, 0) == 0);
      run_frame(W'($urandom), to_idx, hold, 1'b0);
    end
    link.load = 1'b0;
    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_transmitter.md
# fpga_transmitter

Sending half of the FPGA-to-FPGA serial link. It sits directly upstream of the link receiver and takes a parallel word from local logic. It runs the receiver's pulse handshake: a start pulse on `send`, then one `send` pulse per data bit on `serial_out`, then a `finish` pulse. After every pulse it waits for the receiver's `acknowledge` pulse before continuing, and it aborts the frame with `error` if an acknowledge does not arrive in time.

## Interface
- `DATA_WIDTH`, default 8: bits per frame, minimum 1.
- `ACK_TIMEOUT`, default 255: clock cycles to wait for `acknowledge` in any wait state before aborting, minimum 1.

- `clock`  input  1  sole clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state.
- `load`  input  1  start request; sampled only in IDLE.
- `data_in`  input  DATA_WIDTH  word to send; captured when `load` is accepted.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when a frame completes.
- `error`  output  1  one-cycle pulse when a frame is aborted on timeout.
- `send`  output  1  to receiver; frame-start pulse and per-bit strobe.
- `serial_out`  output  1  to receiver; current data bit.
- `finish`  output  1  to receiver; end-of-frame pulse.
- `acknowledge`  input  1  from receiver; one-cycle pulse per handshake.

## Operation
- Reset values: all outputs 0; state IDLE; shift register 0; counters 0.
- The state machine has eight states:
  - IDLE: on `load`, capture `data_in` into the shift register, set `bit_cnt = DATA_WIDTH-1`, go to START_PULSE.
  - START_PULSE: `send=1` for one cycle, then START_WAIT.
  - START_WAIT: on acknowledge, go to BIT_SETUP.
  - BIT_SETUP: `serial_out` = shift register MSB, `send=0`; one cycle, then BIT_PULSE.
  - BIT_PULSE: `send=1`, `serial_out` held; one cycle, then BIT_WAIT.
  - BIT_WAIT: on acknowledge, shift the register left by 1. If `bit_cnt==0` go to FIN_PULSE; otherwise decrement `bit_cnt` and go to BIT_SETUP.
  - FIN_PULSE: `finish=1` for one cycle, then FIN_WAIT.
  - FIN_WAIT: on acknowledge, go to IDLE and pulse `done`.
- Data goes out MSB first. `serial_out` is stable from BIT_SETUP through the end of BIT_WAIT.
- `send` and `finish` are never high in the same cycle.
- `acknowledge` is acted on only in the three WAIT states. Pulses seen in any other state are ignored.
- The timeout counter clears on entry to each WAIT state and increments every cycle spent in it. When it reaches `ACK_TIMEOUT` without an acknowledge:
  - pulse `error`;
  - go to IDLE;
  - leave `done` low.
- If acknowledge and timeout land in the same cycle, acknowledge wins.
- `load` while busy is ignored; there is no queuing. `data_in` is don't-care after capture.
- `reset` asserted mid-frame immediately forces IDLE with all outputs 0. No `done` or `error` pulse is produced.

## Timing
- All outputs are registered (Moore decode of the state register). No combinational path from inputs to outputs.
- `load` high at edge N: `send=1` and `busy=1` during cycle N+1.
- Without synchronizer, acknowledge sampled at edge M in a WAIT state: next state in cycle M+1.
- Per bit: 2 cycles + acknowledge wait.
- Frame length: 2 + 2·DATA_WIDTH + 1 cycles, plus all acknowledge waits.
- `done` and `error` are high in the first IDLE cycle. `load` is accepted in that same cycle, so frames can run back-to-back.

## Configuration
- `FPGA_TX_ACK_SYNC_EN` defined: `acknowledge` passes through a two-flop synchronizer, then a rising-edge detector, before the state machine sees it.
  - Adds 2 cycles of acknowledge latency.
  - Timeout counting is unchanged and includes this delay.
- Not defined: `acknowledge` is used directly as a same-clock pulse.

## Structure
- Package `fpga_link_pkg` holds:
  - the state encoding typedef, shared with the receiver's state constants;
  - default constants `LINK_DATA_WIDTH=8` and `LINK_ACK_TIMEOUT=255`.
- Timeout counter width is `$clog2(ACK_TIMEOUT+1)`.
- One sub-module, `fpga_ack_sync`: synchronizer plus edge detect, instantiated only under `FPGA_TX_ACK_SYNC_EN`.

## Test plan
- `data_in=8'hA5`, `load` one cycle, acknowledge 2 cycles after each `send` or `finish` pulse → `serial_out` bits at BIT_PULSE are 1,0,1,0,0,1,0,1. Eight bit strobes follow the start pulse, one `finish`, then `done`. `error` stays 0.
- No acknowledge after the start pulse, `ACK_TIMEOUT=4` → `error` pulses exactly 4 cycles after entering START_WAIT, then IDLE. `send` and `finish` stay 0 afterwards.
- `load` held high throughout a frame with a stray acknowledge during BIT_SETUP → only one frame is sent, the stray pulse is ignored, and the next frame starts in the cycle `done` is high.
- `reset` driven low during the 4th bit's BIT_WAIT → all outputs 0 asynchronously. After release, `busy=0` and no `done`/`error`.
- `DATA_WIDTH=1`, `data_in=1` → one bit strobe with `serial_out=1`, then `finish`. Total 5 cycles plus waits.
- `FPGA_TX_ACK_SYNC_EN` defined, acknowledge 1 cycle after each pulse → each WAIT state lasts 3 cycles. Data identical to the first scenario.
